// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP sizing helpers for the moving averager
package dsp_pkg;

   function automatic int depth(input int log2_depth);
      return 1 << log2_depth;
   endfunction

   // One extra bit per doubling of the window keeps the running sum from overflowing.
   function automatic int sum_width(input int data_w, input int log2_depth);
      return data_w + log2_depth;
   endfunction

endpackage

// File: rtl/sample_ring.sv
// rtl/sample_ring.sv - circular sample buffer returning the slot about to be overwritten
module sample_ring
   import dsp_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LOG2_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] oldest
);

   localparam int DEPTH = depth(LOG2_DEPTH);

   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [DATA_W-1:0]     mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wr_ptr <= '0;
      else if (clear)
         wr_ptr <= '0;
      else if (wr_en)
         wr_ptr <= wr_ptr + 1'b1;
   end

   // Storage is never reset; the fill count in the parent masks stale slots.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   assign oldest = mem[wr_ptr];

endmodule

// File: rtl/moving_averager.sv
// rtl/moving_averager.sv - boxcar average of samples taken on NCO phase-bit toggles
module moving_averager
   import dsp_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LOG2_DEPTH = 4,
   parameter int PHASE_W    = 32,
   parameter int PHASE_BIT  = 29
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PHASE_W-1:0]       phase,
   input  logic signed [DATA_W-1:0] signal,
   input  logic                     enable,
   input  logic                     clear,
   output logic signed [DATA_W-1:0] filtered,
   output logic                     valid,
   output logic                     sample_stb
);

   localparam int DEPTH = depth(LOG2_DEPTH);
   localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
   localparam int CNT_W = LOG2_DEPTH + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic                    prev_bit;
   logic                    primed;
   logic                    phase_bit;
   logic                    sample_evt;
   logic                    accept;
   logic [DATA_W-1:0]       ring_oldest;
   logic [CNT_W-1:0]        count;
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] sum_next;
   logic signed [SUM_W-1:0] signal_ext;
   logic signed [SUM_W-1:0] oldest_ext;
   logic signed [SUM_W-1:0] avg_full;
   logic                    unused_phase;
   logic                    unused_avg;

   assign phase_bit    = phase[PHASE_BIT];
   assign unused_phase = ^phase;
   assign sample_evt   = primed && (phase_bit != prev_bit);
   assign accept       = sample_evt && enable && !clear;
   assign valid        = (count == FULL);

   // The first clock after reset only captures the phase bit, so no false event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_bit <= 1'b0;
         primed   <= 1'b0;
      end else begin
         prev_bit <= phase_bit;
         primed   <= 1'b1;
      end
   end

   sample_ring #(
      .DATA_W     (DATA_W),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_ring (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .wr_en   (accept),
      .wr_data (signal),
      .oldest  (ring_oldest)
   );

   always_comb begin
      signal_ext = {{LOG2_DEPTH{signal[DATA_W-1]}}, signal};
      oldest_ext = '0;
      if (valid)
         oldest_ext = {{LOG2_DEPTH{ring_oldest[DATA_W-1]}}, ring_oldest};
      sum_next = sum + signal_ext - oldest_ext;
      avg_full = sum_next >>> LOG2_DEPTH;
   end

   assign unused_avg = ^avg_full[SUM_W-1:DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum        <= '0;
         count      <= '0;
         filtered   <= '0;
         sample_stb <= 1'b0;
      end else if (clear) begin
         sum        <= '0;
         count      <= '0;
         filtered   <= '0;
         sample_stb <= 1'b0;
      end else begin
         sample_stb <= accept;
         if (accept) begin
            sum      <= sum_next;
            filtered <= avg_full[DATA_W-1:0];
            if (count != FULL)
               count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_moving_averager.sv
// tb/tb_moving_averager.sv - directed table-driven bench for moving_averager
module tb_moving_averager;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       phase;
   logic signed [7:0] signal;
   logic              enable;
   logic              clear;
   logic signed [7:0] filtered;
   logic              valid;
   logic              sample_stb;

   int total = 0;
   int bad   = 0;
   logic cur_bit;

   typedef struct {
      int sig;
      bit en;
      bit clr;
      bit tog;
      int f;
      bit v;
      bit s;
   } vec_t;

   vec_t vecs[$];

   moving_averager #(
      .DATA_W     (8),
      .LOG2_DEPTH (4),
      .PHASE_W    (32),
      .PHASE_BIT  (29)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .phase      (phase),
      .signal     (signal),
      .enable     (enable),
      .clear      (clear),
      .filtered   (filtered),
      .valid      (valid),
      .sample_stb (sample_stb)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   function automatic void add(input int sig, input bit en, input bit clr, input bit tog,
                               input int f, input bit v, input bit s);
      vec_t t;
      t.sig = sig; t.en = en; t.clr = clr; t.tog = tog;
      t.f = f; t.v = v; t.s = s;
      vecs.push_back(t);
   endfunction

   task automatic apply(input vec_t t, input string tag);
      logic [31:0] p;
      @(negedge clk);
      signal = 8'(t.sig);
      enable = t.en;
      clear  = t.clr;
      p      = $urandom;
      p[29]  = t.tog ? ~cur_bit : cur_bit;
      cur_bit = p[29];
      phase  = p;
      @(posedge clk);
      #1;
      chk({tag, " filtered"}, int'(filtered), t.f);
      chk({tag, " valid"}, int'(valid), int'(t.v));
      chk({tag, " sample_stb"}, int'(sample_stb), int'(t.s));
   endtask

   initial begin
      int up[16];
      int dn[16];
      vec_t t;

      up = '{7, 15, 23, 31, 39, 47, 55, 63, 71, 79, 87, 95, 103, 111, 119, 127};
      dn = '{111, 95, 79, 63, 47, 31, 15, -1, -17, -33, -49, -65, -81, -97, -113, -128};

      for (int k = 1; k <= 16; k++) add(16, 1, 0, 1, k, k == 16, 1);
      add(0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) add(127, 1, 0, 1, up[i], i == 15, 1);
      for (int i = 0; i < 16; i++) add(-128, 1, 0, 1, dn[i], 1, 1);
      add(0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) add(-1, 1, 0, 1, -1, i == 15, 1);
      add(0, 1, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 9; k++) add(3, 1, 0, 1, (3 * k) / 16, 0, 1);
      add(3, 1, 1, 1, 0, 0, 0);
      for (int k = 1; k <= 16; k++) add(5, 1, 0, 1, (5 * k) / 16, k == 16, 1);
      for (int i = 0; i < 8; i++) add(99, 0, 0, 1, 5, 1, 0);
      add(21, 1, 0, 1, 6, 1, 1);
      add(21, 1, 0, 0, 6, 1, 0);

      rst_n  = 1'b0;
      phase  = 32'h2000_0000;
      signal = '0;
      enable = 1'b1;
      clear  = 1'b0;
      cur_bit = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset filtered", int'(filtered), 0);
      chk("reset valid", int'(valid), 0);
      chk("reset sample_stb", int'(sample_stb), 0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         chk("idle sample_stb", int'(sample_stb), 0);
         chk("idle filtered", int'(filtered), 0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         t = vecs[i];
         apply(t, $sformatf("vec%0d", i));
      end

      @(negedge clk);
      rst_n = 1'b0;
      phase = 32'h2000_0000;
      cur_bit = 1'b1;
      #1;
      chk("midreset filtered", int'(filtered), 0);
      chk("midreset valid", int'(valid), 0);
      chk("midreset sample_stb", int'(sample_stb), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("prime sample_stb", int'(sample_stb), 0);
      t.sig = 32; t.en = 1; t.clr = 0; t.tog = 1; t.f = 2; t.v = 0; t.s = 1;
      apply(t, "post-reset event");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
